randomized_lfsr_pool: RTL and testbench

//  Parametrised random-word generator. Combines SOURCES external metastable oscillator bits,

---
 rtl/randomized_lfsr_pool_pkg.sv | 29 ++
 rtl/randomized_lfsr_pool_von_neumann_extractor.sv | 50 +++++
 rtl/randomized_lfsr_pool.sv | 157 +++++++++++++++
 tb/tb_randomized_lfsr_pool.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/randomized_lfsr_pool_pkg.sv
// ----------------------------------------------------------------------------
// randomized_lfsr_pool_pkg : shared RNG defaults and extractor state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package randomized_lfsr_pool_pkg;

  // Default WIDTH/INIT/FEEDBACK triples shared by the weak and pool generators
  localparam int          RNG8_WIDTH     = 8;
  localparam logic [7:0]  RNG8_INIT      = 8'hE1;
  localparam logic [7:0]  RNG8_FEEDBACK  = 8'hB8;

  localparam int          RNG16_WIDTH    = 16;
  localparam logic [15:0] RNG16_INIT     = 16'hACE1;
  localparam logic [15:0] RNG16_FEEDBACK = 16'hB400;

  localparam int          RNG32_WIDTH    = 32;
  localparam logic [31:0] RNG32_INIT     = 32'hACE1_2468;
  localparam logic [31:0] RNG32_FEEDBACK = 32'h8020_0003;

  typedef enum logic [0:0] {
    VN_EMPTY = 1'b0,
    VN_HAVE  = 1'b1
  } vn_state_e;

endpackage

`default_nettype wire

// File: rtl/randomized_lfsr_pool_von_neumann_extractor.sv
// ----------------------------------------------------------------------------
// von_neumann_extractor : pairs raw samples, emits the first bit of each 01/10
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module von_neumann_extractor
  import randomized_lfsr_pool_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic out_valid
);

  vn_state_e state_q, state_d;
  logic      first_q, first_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= VN_EMPTY;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    first_d   = first_q;
    out       = first_q;
    out_valid = 1'b0;
    case (state_q)
      VN_EMPTY: begin
        first_d = in;
        state_d = VN_HAVE;
      end
      VN_HAVE: begin
        out_valid = (in != first_q);
        state_d   = VN_EMPTY;
      end
      default: state_d = VN_EMPTY;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/randomized_lfsr_pool.sv
// ----------------------------------------------------------------------------
// randomized_lfsr_pool : entropy-fed LFSR word generator with health monitor
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module randomized_lfsr_pool
  import randomized_lfsr_pool_pkg::*;
#(
  parameter int               WIDTH        = RNG16_WIDTH,
  parameter logic [WIDTH-1:0] INIT_VALUE   = RNG16_INIT,
  parameter logic [WIDTH-1:0] FEEDBACK     = RNG16_FEEDBACK,
  parameter int               SOURCES      = 4,
  parameter int               DEBIAS       = 1,
  parameter int               MIX_ROUNDS   = 2,
  parameter int               REPEAT_LIMIT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SOURCES-1:0] entropy_in,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               metastable,
  output logic               health_fail
);

  localparam int FILL_MAX = WIDTH * MIX_ROUNDS;
  localparam int FILL_W   = $clog2(FILL_MAX + 1);
  localparam int RUN_W    = $clog2(REPEAT_LIMIT + 1);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FILL_MAX);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [RUN_W-1:0]  RUN_LIM   = RUN_W'(REPEAT_LIMIT);
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);

  logic [SOURCES-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]         prime_q, prime_d;
  logic               prev_q, prev_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               health_fail_q, health_fail_d;
  logic [WIDTH-1:0]   lfsr_q, lfsr_d, lfsr_next;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               out_valid_q, out_valid_d;

  logic raw, raw_valid;
  logic bit_val, bit_valid;

  // prime_q marks when sync2 holds a real sample rather than its reset zero
  assign raw       = ^sync2_q;
  assign raw_valid = prime_q[1];

  generate
    if (DEBIAS != 0) begin : g_debias
      logic vn_rst;
      logic vn_bit;
      logic vn_valid;

      assign vn_rst = rst | ~raw_valid;

      von_neumann_extractor u_vn (
        .clk       (clk),
        .rst       (vn_rst),
        .in        (raw),
        .out       (vn_bit),
        .out_valid (vn_valid)
      );

      assign bit_val   = vn_bit;
      assign bit_valid = vn_valid;
    end else begin : g_raw
      assign bit_val   = raw;
      assign bit_valid = raw_valid;
    end
  endgenerate

  always_comb begin
    sync1_d = entropy_in;
    sync2_d = sync1_q;
    prime_d = {prime_q[0], 1'b1};

    prev_d        = prev_q;
    run_d         = run_q;
    health_fail_d = health_fail_q;
    if (raw_valid) begin
      prev_d = raw;
      if (raw != prev_q) begin
        run_d = RUN_ONE;
      end else if (run_q != RUN_LIM) begin
        run_d = run_q + RUN_ONE;
      end
      if (run_d == RUN_LIM) begin
        health_fail_d = 1'b1;
      end
    end

    lfsr_next = {lfsr_q[WIDTH-2:0], (^(lfsr_q & FEEDBACK)) ^ bit_val};
    lfsr_d    = lfsr_q;
    fill_d    = fill_q;
    if (bit_valid && !health_fail_q) begin
      lfsr_d = (lfsr_next == '0) ? INIT_VALUE : lfsr_next;
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FILL_ONE;
      end
    end

    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    // Load takes priority over the absorb count update on the same edge
    if (!out_valid_q && (fill_q == FILL_FULL) && !health_fail_q) begin
      out_d       = lfsr_q;
      out_valid_d = 1'b1;
      fill_d      = '0;
    end
    if (health_fail_d) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      prime_q       <= '0;
      prev_q        <= 1'b0;
      run_q         <= '0;
      health_fail_q <= 1'b0;
      lfsr_q        <= INIT_VALUE;
      fill_q        <= '0;
      out_q         <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prime_q       <= prime_d;
      prev_q        <= prev_d;
      run_q         <= run_d;
      health_fail_q <= health_fail_d;
      lfsr_q        <= lfsr_d;
      fill_q        <= fill_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign out         = out_q;
  assign out_valid   = out_valid_q;
  assign metastable  = raw;
  assign health_fail = health_fail_q;

endmodule

`default_nettype wire

// File: tb/tb_randomized_lfsr_pool.sv
// ----------------------------------------------------------------------------
// tb_randomized_lfsr_pool : scoreboard bench for two pool configurations
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_randomized_lfsr_pool;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst     = 1'b1;
  logic [1:0] ent_a   = 2'b00;
  logic       ent_b   = 1'b0;
  logic       ready_a = 1'b1;
  logic       ready_b = 1'b1;

  logic [15:0] out_a, out_b;
  logic        valid_a, valid_b, meta_a, meta_b, fail_a, fail_b;

  randomized_lfsr_pool #(
    .WIDTH(16), .INIT_VALUE(16'hACE1), .FEEDBACK(16'hB400),
    .SOURCES(2), .DEBIAS(0), .MIX_ROUNDS(2), .REPEAT_LIMIT(32)
  ) dut_a (
    .clk(clk), .rst(rst), .entropy_in(ent_a), .out(out_a), .out_valid(valid_a),
    .out_ready(ready_a), .metastable(meta_a), .health_fail(fail_a)
  );

  randomized_lfsr_pool #(
    .WIDTH(16), .INIT_VALUE(16'hACE1), .FEEDBACK(16'hB400),
    .SOURCES(1), .DEBIAS(1), .MIX_ROUNDS(2), .REPEAT_LIMIT(32)
  ) dut_b (
    .clk(clk), .rst(rst), .entropy_in(ent_b), .out(out_b), .out_valid(valid_b),
    .out_ready(ready_b), .metastable(meta_b), .health_fail(fail_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model, cycle by cycle
  typedef struct {
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [1:0]  prime;
    logic        prev;
    int          run;
    logic        fail;
    logic        have;
    logic        first;
    logic [15:0] lfsr;
    int          fill;
    logic [15:0] out;
    logic        ov;
  } model_t;

  function automatic model_t model_step(model_t m, logic [1:0] ent, logic ready, logic r, bit debias);
    model_t      n;
    logic        raw, rv, bv, b;
    logic [15:0] nxt;
    n = m;
    if (r) begin
      n.s1 = '0; n.s2 = '0; n.prime = '0; n.prev = 1'b0; n.run = 0; n.fail = 1'b0;
      n.have = 1'b0; n.first = 1'b0; n.lfsr = 16'hACE1; n.fill = 0; n.out = '0; n.ov = 1'b0;
      return n;
    end
    raw     = ^m.s2;
    rv      = m.prime[1];
    n.s1    = ent;
    n.s2    = m.s1;
    n.prime = {m.prime[0], 1'b1};
    if (rv) begin
      n.prev = raw;
      n.run  = (raw == m.prev) ? m.run + 1 : 1;
      if (n.run >= 32) n.fail = 1'b1;
    end
    bv = 1'b0;
    b  = 1'b0;
    if (!debias) begin
      bv = rv;
      b  = raw;
    end else if (!rv) begin
      n.have = 1'b0;
    end else if (!m.have) begin
      n.have  = 1'b1;
      n.first = raw;
    end else begin
      n.have = 1'b0;
      if (raw != m.first) begin
        bv = 1'b1;
        b  = m.first;
      end
    end
    if (bv && !m.fail) begin
      nxt    = {m.lfsr[14:0], (^(m.lfsr & 16'hB400)) ^ b};
      n.lfsr = (nxt == 16'h0000) ? 16'hACE1 : nxt;
      if (m.fill < 32) n.fill = m.fill + 1;
    end
    if (m.ov && ready) n.ov = 1'b0;
    if (!m.ov && m.fill == 32 && !m.fail) begin
      n.out  = m.lfsr;
      n.ov   = 1'b1;
      n.fill = 0;
    end
    if (n.fail) n.ov = 1'b0;
    return n;
  endfunction

  // State after absorbing 32 bits alternating 0,1,0,1... from the init value
  function automatic logic [15:0] alt_word();
    logic [15:0] s, nxt;
    s = 16'hACE1;
    for (int i = 0; i < 32; i++) begin
      nxt = {s[14:0], (^(s & 16'hB400)) ^ i[0]};
      s   = (nxt == 16'h0000) ? 16'hACE1 : nxt;
    end
    return s;
  endfunction

  model_t      ma, mb, na, nb;
  logic [15:0] qa[$];
  logic [15:0] qb[$];

  always @(posedge clk) begin
    na = model_step(ma, ent_a, ready_a, rst, 1'b0);
    nb = model_step(mb, {1'b0, ent_b}, ready_b, rst, 1'b1);
    if (rst) begin
      qa.delete();
      qb.delete();
    end
    if (na.ov && !ma.ov) qa.push_back(na.out);
    if (nb.ov && !mb.ov) qb.push_back(nb.out);
    ma <= na;
    mb <= nb;
  end

  bit          chk_en = 1'b0;
  logic        prev_va = 1'b0, prev_vb = 1'b0;
  logic [31:0] exp_a, exp_b;
  bit          b_seen = 1'b0;
  logic [15:0] b_first = '0;

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check_eq("a_valid", 32'(valid_a), 32'(ma.ov));
      check_eq("a_fail",  32'(fail_a),  32'(ma.fail));
      check_eq("a_meta",  32'(meta_a),  32'(^ma.s2));
      check_eq("a_out",   32'(out_a),   32'(ma.out));
      if (valid_a && !prev_va) begin
        exp_a = (qa.size() > 0) ? 32'(qa.pop_front()) : 32'h0001_0000;
        check_eq("a_word", 32'(out_a), exp_a);
      end
      check_eq("b_valid", 32'(valid_b), 32'(mb.ov));
      check_eq("b_fail",  32'(fail_b),  32'(mb.fail));
      check_eq("b_meta",  32'(meta_b),  32'(^mb.s2));
      check_eq("b_out",   32'(out_b),   32'(mb.out));
      if (valid_b && !prev_vb) begin
        exp_b = (qb.size() > 0) ? 32'(qb.pop_front()) : 32'h0001_0000;
        check_eq("b_word", 32'(out_b), exp_b);
        if (!b_seen) begin
          b_seen  = 1'b1;
          b_first = out_b;
        end
      end
    end
    if (rst) b_seen = 1'b0;
    prev_va = valid_a;
    prev_vb = valid_b;
  end

  // Stimulus generators: mode_a selects the dut_a source pattern
  int          mode_a = 0;
  logic [31:0] cyc    = '0;
  logic [7:0]  pat_b  = 8'hC6;

  task automatic drive();
    if (rst) cyc = '0;
    else     cyc = cyc + 1;
    case (mode_a)
      0:       ent_a = {1'b0, cyc[0]};
      1:       ent_a = 2'b00;
      2:       ent_a = {cyc[0], cyc[0]};
      default: ent_a = {cyc[1], cyc[0]};
    endcase
    ent_b = pat_b[cyc[2:0]];
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
    drive();
  endtask

  int          n;
  logic [15:0] first_a, held;

  initial begin
    repeat (3) cycle();
    chk_en = 1'b1;
    check_eq("rst_out",   32'(out_a),   32'h0);
    check_eq("rst_valid", 32'(valid_a), 32'h0);
    check_eq("rst_fail",  32'(fail_a),  32'h0);
    check_eq("rst_meta",  32'(meta_a),  32'h0);

    // Toggling single source, consumer always ready
    rst = 1'b0;
    n   = 0;
    while (!valid_a && n < 100) begin cycle(); n++; end
    check_eq("s1_latency", 32'(n), 32'd35);
    check_eq("s1_first_word", 32'(out_a), 32'(alt_word()));
    first_a = out_a;
    repeat (150) cycle();
    check_eq("s1_health", 32'(fail_a), 32'h0);
    check_eq("s2_debias_seen", 32'(b_seen), 32'h1);
    check_eq("s2_debias_word", 32'(b_first), 32'(alt_word()));

    // Backpressure then a single accept pulse
    ready_a = 1'b0;
    n = 0;
    while (!valid_a && n < 100) begin cycle(); n++; end
    held = out_a;
    repeat (200) cycle();
    check_eq("s5_hold_out",   32'(out_a),   32'(held));
    check_eq("s5_hold_valid", 32'(valid_a), 32'h1);
    ready_a = 1'b1;
    cycle();
    ready_a = 1'b0;
    check_eq("s5_drop", 32'(valid_a), 32'h0);
    cycle();
    check_eq("s5_reload", 32'(valid_a), 32'h1);
    check_eq("s5_new_value", 32'(out_a != held), 32'h1);

    // Reset mid-handshake with a partly filled pool
    repeat (17) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_eq("s6_out",   32'(out_a),   32'h0);
    check_eq("s6_valid", 32'(valid_a), 32'h0);
    check_eq("s6_fail",  32'(fail_a),  32'h0);
    check_eq("s6_meta",  32'(meta_a),  32'h0);
    ready_a = 1'b1;
    n = 0;
    while (!valid_a && n < 100) begin cycle(); n++; end
    check_eq("s6_latency", 32'(n), 32'd35);
    check_eq("s6_word", 32'(out_a), 32'(first_a));

    // Stuck source
    mode_a = 1;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n = 0;
    while (!fail_a && n < 100) begin cycle(); n++; end
    check_eq("s3_trip", 32'(n), 32'd34);
    mode_a = 0;
    repeat (60) cycle();
    check_eq("s3_sticky", 32'(fail_a),  32'h1);
    check_eq("s3_novalid", 32'(valid_a), 32'h0);

    // Two sources toggling identically cancel out
    mode_a = 2;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n = 0;
    while (!fail_a && n < 100) begin cycle(); n++; end
    check_eq("s4_same_trip", 32'(n), 32'd34);

    // Two sources toggling differently
    mode_a = 3;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (120) cycle();
    check_eq("s4_distinct_ok", 32'(fail_a), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
